adder_pipe_n: RTL and testbench
===============================

# adder_pipe_n

Parametrised pipelined adder: successor to the fixed 32-bit two-stage adder. Splits a WIDTH-bit addition into STAGES equal segments, one segment per pipeline stage, with the carry registered between stages. Adds a valid/ready handshake with backpressure so it can sit directly in streaming datapaths. Throughput is one result per cycle; latency is STAGES cycles.

## Interface
Parameters:
- WIDTH, 32, operand width in bits; must be divisible by STAGES.
- STAGES, 2, pipeline depth and segment count; range 1..WIDTH.

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_1  in  WIDTH  operand A.
- in_2  in  WIDTH  operand B.
- in_valid  in  1  operands valid this cycle.
- in_ready  out  1  pipeline can accept this cycle (combinational).
- out_sum  out  WIDTH+1  result; bit WIDTH is the final carry.
- out_valid  out  1  out_sum holds a new result.
- out_ready  in  1  downstream accepts the result this cycle.
- in_sub  in  1  present only with ADDER_PIPE_SUB_EN; 1 = subtract.

## Operation
- SEG = WIDTH/STAGES. Stage k (k = 0..STAGES-1) adds bits [k*SEG +: SEG] of both operands plus the carry registered by stage k-1 (stage 0 carry-in = 0, or in_sub under the macro).
- Each stage register holds: a valid bit, the completed low segments, the not-yet-added high operand bits, and the carry out.
- advance = !out_valid || out_ready. in_ready = advance.
- When advance = 1, every stage loads from its predecessor; stage 0 loads in_valid and the operands. When advance = 0, all stage registers hold (global stall; bubbles are not compressed).
- An accepted transfer is in_valid && in_ready. in_valid with in_ready low is ignored; the source must hold.
- The output stage loads out_sum only when advance && incoming valid = 1. Otherwise out_sum holds the last result. out_valid takes the incoming valid bit on every advance.
- Arithmetic: out_sum = {carry, sum} = in_1 + in_2, unsigned, zero-extended to WIDTH+1. It never wraps.
- Reset: all stage valid bits = 0, out_valid = 0, out_sum = 0, in-flight data discarded. in_ready = 1 in the first cycle after reset. Reset asserted mid-operation flushes all in-flight operations and wins over any simultaneous transfer.

## Timing
- Transfer accepted at edge t. With no stall, the result appears with out_valid = 1 after edge t+STAGES-1, so it is visible in the cycle ending at edge t+STAGES. STAGES = 1 gives a single registered adder.
- Each cycle with advance = 0 adds one cycle of latency to every in-flight operation.
- Back-to-back transfers give back-to-back results, one per cycle.
- out_valid && !out_ready: out_sum and out_valid are stable until the handshake completes. out_ready may be high while out_valid is low (no effect beyond advance).

## Configuration
- ADDER_PIPE_SUB_EN defined:
  - The in_sub port exists. in_sub is sampled with the operands and travels through the pipeline with them.
  - in_sub = 1 computes in_1 + ~in_2 + 1. out_sum[WIDTH] = 1 when in_1 >= in_2 (no borrow), and 0 otherwise.
  - in_sub = 0 behaves exactly as without the macro.
- ADDER_PIPE_SUB_EN undefined: no in_sub port; add only.

## Test plan
- WIDTH=32, STAGES=2, out_ready=1: 3827 + 9273 accepted at edge t -> out_sum = 13100, out_valid = 1 after edge t+1. Then 0 + 9253 -> 9253, and 200 + 100 -> 300 on consecutive cycles.
- Cross-segment carry: 32'hFFFFFFFF + 32'h00000001 -> 33'h1_00000000. 32'h0FFFFFFF + 32'hFFFFFFEF -> 33'h1_0FFFFFEE. Repeat with STAGES = 1, 4 and 8 and check the same results at latency STAGES.
- Backpressure: stream 1, 2, 3, 4 (+0). Drop out_ready for 3 cycles while result 1 is valid -> in_ready = 0, out_sum holds 1. After release, 1, 2, 3, 4 are delivered in order with none lost or duplicated.
- Bubbles: in_valid pattern 1,0,1 with 13442 + 10042 then 1 + 0 -> outputs 23484, one out_valid=0 cycle with out_sum held at 23484, then 1.
- Reset mid-flight: assert reset for one cycle with 2 operations in flight -> next cycle out_valid = 0, out_sum = 0, in_ready = 1, and no stale results emerge later.
- With ADDER_PIPE_SUB_EN: 200 - 100 -> 33'h1_00000064. 100 - 200 -> 33'h0_FFFFFF9C. Alternate in_sub every cycle and check each result matches its own in_sub.

Source files
------------

// File: rtl/adder_pipe_n.sv
// Pipelined WIDTH-bit adder, one SEG-bit segment per stage, with a valid/ready stream handshake.
// Optional subtract support is compiled in when ADDER_PIPE_SUB_EN is defined (adds the in_sub port).
module adder_pipe_n #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_1,
   input  logic [WIDTH-1:0] in_2,
   input  logic             in_valid,
   output logic             in_ready,
`ifdef ADDER_PIPE_SUB_EN
   input  logic             in_sub,
`endif
   output logic [WIDTH:0]   out_sum,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int SEG = WIDTH / STAGES;

   // Stage registers: operands still to be added, completed low segments, carry out, valid
   logic [WIDTH-1:0] a_r   [STAGES];
   logic [WIDTH-1:0] b_r   [STAGES];
   logic [WIDTH-1:0] s_r   [STAGES];
   logic             c_r   [STAGES];
   logic             v_r   [STAGES];

   logic [WIDTH-1:0] src_a_s   [STAGES];
   logic [WIDTH-1:0] src_b_s   [STAGES];
   logic [WIDTH-1:0] src_s_s   [STAGES];
   logic             src_c_s   [STAGES];
   logic             src_v_s   [STAGES];
   logic [WIDTH-1:0] nxt_s_s   [STAGES];
   logic             nxt_c_s   [STAGES];
   logic [SEG:0]     seg_sum_s [STAGES];

   logic             advance_s;
   logic             cin0_s;
   logic [WIDTH-1:0] op_b_s;

`ifdef ADDER_PIPE_SUB_EN
   // Subtraction folds into stage 0 as in_1 + ~in_2 + 1; the inverted operand rides the pipe.
   assign cin0_s = in_sub;
   assign op_b_s = in_sub ? ~in_2 : in_2;
`else
   assign cin0_s = 1'b0;
   assign op_b_s = in_2;
`endif

   // Global stall: the whole pipe moves only when the output slot is free or being drained
   assign advance_s = !out_valid || out_ready;
   assign in_ready  = advance_s;
   assign out_valid = v_r[STAGES-1];
   assign out_sum   = {c_r[STAGES-1], s_r[STAGES-1]};

   // Stage sources and per-stage segment adders
   always_comb begin
      src_a_s[0] = in_1;
      src_b_s[0] = op_b_s;
      src_s_s[0] = {WIDTH{1'b0}};
      src_c_s[0] = cin0_s;
      src_v_s[0] = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         src_a_s[k] = a_r[k-1];
         src_b_s[k] = b_r[k-1];
         src_s_s[k] = s_r[k-1];
         src_c_s[k] = c_r[k-1];
         src_v_s[k] = v_r[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         seg_sum_s[k] = {1'b0, src_a_s[k][k*SEG +: SEG]}
                      + {1'b0, src_b_s[k][k*SEG +: SEG]}
                      + {{SEG{1'b0}}, src_c_s[k]};
         nxt_s_s[k]                = src_s_s[k];
         nxt_s_s[k][k*SEG +: SEG]  = seg_sum_s[k][SEG-1:0];
         nxt_c_s[k]                = seg_sum_s[k][SEG];
      end
   end

   // Pipeline registers; data only loads with a valid token so the output holds across bubbles
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < STAGES; k++) begin
            v_r[k] <= 1'b0;
            a_r[k] <= {WIDTH{1'b0}};
            b_r[k] <= {WIDTH{1'b0}};
            s_r[k] <= {WIDTH{1'b0}};
            c_r[k] <= 1'b0;
         end
      end else if (advance_s) begin
         for (int k = 0; k < STAGES; k++) begin
            v_r[k] <= src_v_s[k];
            if (src_v_s[k]) begin
               a_r[k] <= src_a_s[k];
               b_r[k] <= src_b_s[k];
               s_r[k] <= nxt_s_s[k];
               c_r[k] <= nxt_c_s[k];
            end
         end
      end
   end

endmodule

// File: tb/tb_adder_pipe_n.sv
// Bench for adder_pipe_n: directed table, hand sequences and randomized stream checked by scoreboards
// on four instances (STAGES = 2, 1, 4, 8).
module tb_adder_pipe_n;

   localparam int MS = 2;
`ifdef ADDER_PIPE_SUB_EN
   localparam bit SUB_ON = 1'b1;
`else
   localparam bit SUB_ON = 1'b0;
`endif

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [32:0] exp;
   } vec_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_sub = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] in_1 = 32'd0;
   logic [31:0] in_2 = 32'd0;

   logic [32:0] sum_a  [4];
   logic        ov_a   [4];
   logic        ir_a   [4];
   logic        ordy_a [4];
   int          stg    [4] = '{MS, 1, 4, 8};

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   assign ordy_a[0] = out_ready;
   assign ordy_a[1] = 1'b1;
   assign ordy_a[2] = 1'b1;
   assign ordy_a[3] = 1'b1;

   adder_pipe_n #(.WIDTH(32), .STAGES(MS)) dut (
      .clock(clock), .reset(reset), .in_1(in_1), .in_2(in_2), .in_valid(in_valid), .in_ready(ir_a[0]),
`ifdef ADDER_PIPE_SUB_EN
      .in_sub(in_sub),
`endif
      .out_sum(sum_a[0]), .out_valid(ov_a[0]), .out_ready(ordy_a[0]));

   adder_pipe_n #(.WIDTH(32), .STAGES(1)) u_s1 (
      .clock(clock), .reset(reset), .in_1(in_1), .in_2(in_2), .in_valid(in_valid), .in_ready(ir_a[1]),
`ifdef ADDER_PIPE_SUB_EN
      .in_sub(in_sub),
`endif
      .out_sum(sum_a[1]), .out_valid(ov_a[1]), .out_ready(ordy_a[1]));

   adder_pipe_n #(.WIDTH(32), .STAGES(4)) u_s4 (
      .clock(clock), .reset(reset), .in_1(in_1), .in_2(in_2), .in_valid(in_valid), .in_ready(ir_a[2]),
`ifdef ADDER_PIPE_SUB_EN
      .in_sub(in_sub),
`endif
      .out_sum(sum_a[2]), .out_valid(ov_a[2]), .out_ready(ordy_a[2]));

   adder_pipe_n #(.WIDTH(32), .STAGES(8)) u_s8 (
      .clock(clock), .reset(reset), .in_1(in_1), .in_2(in_2), .in_valid(in_valid), .in_ready(ir_a[3]),
`ifdef ADDER_PIPE_SUB_EN
      .in_sub(in_sub),
`endif
      .out_sum(sum_a[3]), .out_valid(ov_a[3]), .out_ready(ordy_a[3]));

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: unsigned sum, or difference with no-borrow flag in the top bit
   function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
      if (s && SUB_ON) return {(a >= b), a - b};
      return {1'b0, a} + {1'b0, b};
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 4))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h0000_FFFF;
         3: return 32'hFFFF_0000;
         default: return $urandom;
      endcase
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Scoreboards: one expectation FIFO per instance, filled on accept, drained on delivery
   logic [32:0] exp_mem  [4][64];
   int          acc_mem  [4][64];
   int          wp [4] = '{0, 0, 0, 0};
   int          rp [4] = '{0, 0, 0, 0};
   logic        held [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
   logic [32:0] held_sum [4];
   logic        hold_src = 1'b0;

   always @(negedge clock) begin
      if (reset) begin
         for (int d = 0; d < 4; d++) begin
            wp[d]   <= 0;
            rp[d]   <= 0;
            held[d] <= 1'b0;
         end
         hold_src <= 1'b0;
      end else begin
         for (int d = 0; d < 4; d++) begin
            if (held[d]) begin
               chk($sformatf("hold_valid_d%0d", d), 64'(ov_a[d]), 64'd1);
               chk($sformatf("hold_sum_d%0d", d), 64'(sum_a[d]), 64'(held_sum[d]));
            end
            if (ov_a[d] && ordy_a[d]) begin
               if (rp[d] == wp[d]) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL extra_result_d%0d: got %0h, expected no result (cycle %0d)", d, sum_a[d], cyc);
               end else begin
                  chk($sformatf("sb_sum_d%0d", d), 64'(sum_a[d]), 64'(exp_mem[d][rp[d] % 64]));
                  if (d != 0) chk($sformatf("sb_latency_d%0d", d), 64'(cyc - acc_mem[d][rp[d] % 64]), 64'(stg[d]));
                  rp[d] <= rp[d] + 1;
               end
            end
            held[d]     <= ov_a[d] && !ordy_a[d];
            held_sum[d] <= sum_a[d];
            if (in_valid && ir_a[d]) begin
               exp_mem[d][wp[d] % 64] <= model(in_1, in_2, in_sub);
               acc_mem[d][wp[d] % 64] <= cyc;
               wp[d] <= wp[d] + 1;
            end
         end
         hold_src <= in_valid && !ir_a[0];
      end
   end

   vec_t tbl [$];
   logic [31:0] ba [3] = '{32'd3827, 32'd0, 32'd200};
   logic [31:0] bb [3] = '{32'd9273, 32'd9253, 32'd100};
   logic [32:0] be [3] = '{33'd13100, 33'd9253, 33'd300};

   initial begin
      tbl.push_back(vec_t'{32'd3827,       32'd9273,       1'b0, 33'd13100});
      tbl.push_back(vec_t'{32'd0,          32'd9253,       1'b0, 33'd9253});
      tbl.push_back(vec_t'{32'd200,        32'd100,        1'b0, 33'd300});
      tbl.push_back(vec_t'{32'hFFFF_FFFF,  32'h0000_0001,  1'b0, 33'h1_0000_0000});
      tbl.push_back(vec_t'{32'h0FFF_FFFF,  32'hFFFF_FFEF,  1'b0, 33'h1_0FFF_FFEE});
      tbl.push_back(vec_t'{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 33'h1_FFFF_FFFE});
      tbl.push_back(vec_t'{32'h0000_FFFF,  32'h0000_0001,  1'b0, 33'h0_0001_0000});
`ifdef ADDER_PIPE_SUB_EN
      tbl.push_back(vec_t'{32'd200,        32'd100,        1'b1, 33'h1_0000_0064});
      tbl.push_back(vec_t'{32'd100,        32'd200,        1'b1, 33'h0_FFFF_FF9C});
      tbl.push_back(vec_t'{32'd5,          32'd5,          1'b1, 33'h1_0000_0000});
`endif

      // Reset state
      step();
      step();
      for (int d = 0; d < 4; d++) begin
         chk($sformatf("rst_valid_d%0d", d), 64'(ov_a[d]), 64'd0);
         chk($sformatf("rst_sum_d%0d", d), 64'(sum_a[d]), 64'd0);
      end
      chk("rst_in_ready", 64'(ir_a[0]), 64'd1);
      reset = 1'b0;
      out_ready = 1'b1;

      // Table: each vector alone, exact latency on the main instance
      for (int i = 0; i < tbl.size(); i++) begin
         in_1 = tbl[i].a; in_2 = tbl[i].b; in_sub = tbl[i].sub; in_valid = 1'b1;
         for (int j = 0; j < MS; j++) begin
            step();
            in_valid = 1'b0;
            if (j < MS - 1) chk($sformatf("tbl%0d_early", i), 64'(ov_a[0]), 64'd0);
         end
         chk($sformatf("tbl%0d_valid", i), 64'(ov_a[0]), 64'd1);
         chk($sformatf("tbl%0d_sum", i), 64'(sum_a[0]), 64'(tbl[i].exp));
      end
      in_sub = 1'b0;
      step();

      // Back-to-back transfers give back-to-back results
      for (int j = 1; j <= 3 + MS - 1; j++) begin
         if (j <= 3) begin
            in_1 = ba[j-1]; in_2 = bb[j-1]; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         step();
         if (j - MS >= 0) begin
            chk($sformatf("b2b%0d_valid", j - MS), 64'(ov_a[0]), 64'd1);
            chk($sformatf("b2b%0d_sum", j - MS), 64'(sum_a[0]), 64'(be[j-MS]));
         end
      end
      in_valid = 1'b0;
      step();
      step();

      // Backpressure: stall three cycles while result 1 is presented
      in_2 = 32'd0; in_1 = 32'd1; in_valid = 1'b1;
      step();
      in_1 = 32'd2;
      step();
      out_ready = 1'b0;
      in_1 = 32'd3;
      #1;
      chk("bp_in_ready", 64'(ir_a[0]), 64'd0);
      chk("bp_sum_first", 64'(sum_a[0]), 64'd1);
      for (int j = 0; j < 3; j++) begin
         step();
         chk("bp_stall_valid", 64'(ov_a[0]), 64'd1);
         chk("bp_stall_sum", 64'(sum_a[0]), 64'd1);
         chk("bp_stall_ready", 64'(ir_a[0]), 64'd0);
      end
      out_ready = 1'b1;
      step();
      chk("bp_sum2", 64'(sum_a[0]), 64'd2);
      in_1 = 32'd4;
      step();
      chk("bp_sum3", 64'(sum_a[0]), 64'd3);
      in_valid = 1'b0;
      step();
      chk("bp_sum4", 64'(sum_a[0]), 64'd4);
      step();
      step();

      // Bubble in the input stream
      in_1 = 32'd13442; in_2 = 32'd10042; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      chk("bub_valid0", 64'(ov_a[0]), 64'd1);
      chk("bub_sum0", 64'(sum_a[0]), 64'd23484);
      in_1 = 32'd1; in_2 = 32'd0; in_valid = 1'b1;
      step();
      chk("bub_gap_valid", 64'(ov_a[0]), 64'd0);
      chk("bub_gap_sum", 64'(sum_a[0]), 64'd23484);
      in_valid = 1'b0;
      step();
      chk("bub_valid1", 64'(ov_a[0]), 64'd1);
      chk("bub_sum1", 64'(sum_a[0]), 64'd1);
      step();

      // Reset with two operations in flight, competing with a new transfer
      in_1 = 32'd5; in_2 = 32'd6; in_valid = 1'b1;
      step();
      in_1 = 32'd7; in_2 = 32'd8;
      step();
      reset = 1'b1;
      in_1 = 32'd9; in_2 = 32'd9;
      step();
      out_ready = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(ov_a[0]), 64'd0);
      chk("mid_rst_sum", 64'(sum_a[0]), 64'd0);
      chk("mid_rst_ready", 64'(ir_a[0]), 64'd1);
      reset = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int j = 0; j < 10; j++) begin
         step();
         chk("mid_rst_no_stale", 64'(ov_a[0] | ov_a[1] | ov_a[2] | ov_a[3]), 64'd0);
      end

`ifdef ADDER_PIPE_SUB_EN
      // Alternate add/subtract every cycle
      for (int j = 0; j < 8; j++) begin
         in_1 = 32'd100 + 32'(j * 50); in_2 = 32'd200; in_sub = j[0]; in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      in_sub = 1'b0;
      repeat (10) step();
`endif

      // Randomized stream with random backpressure; source holds while not ready
      for (int j = 0; j < 600; j++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         if (!hold_src) begin
            in_valid = ($urandom_range(0, 9) < 7);
            in_1 = pick();
            in_2 = pick();
            in_sub = SUB_ON & $urandom_range(0, 1);
         end
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (12) step();
      for (int d = 0; d < 4; d++) chk($sformatf("drained_d%0d", d), 64'(wp[d] - rp[d]), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
